// File: rtl/spi_pkg.sv
`default_nettype none
// =====================================================================
// spi_pkg: register map and status/control bit positions shared by the
// SPI master and slave peripherals.  Revision: 1.0
// =====================================================================
package spi_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_RXDATA  = 3'd0;
  localparam reg_addr_t ADDR_TXDATA  = 3'd1;
  localparam reg_addr_t ADDR_STATUS  = 3'd2;
  localparam reg_addr_t ADDR_CONTROL = 3'd3;
  localparam reg_addr_t ADDR_EOP     = 3'd6;

  localparam int ST_ROE  = 3;
  localparam int ST_TOE  = 4;
  localparam int ST_TMT  = 5;
  localparam int ST_TRDY = 6;
  localparam int ST_RRDY = 7;
  localparam int ST_E    = 8;
  localparam int ST_EOP  = 9;

  localparam int CTL_IROE  = 3;
  localparam int CTL_ITOE  = 4;
  localparam int CTL_ITRDY = 6;
  localparam int CTL_IRRDY = 7;
  localparam int CTL_IE    = 8;
  localparam int CTL_IEOP  = 9;

  localparam logic [15:0] CTL_MASK = 16'h03D8;

endpackage
`default_nettype wire

// File: rtl/spi_slave_port_if.sv
`default_nettype none
// =====================================================================
// spi_slave_port_if: CPU-side register bus of the SPI slave port.
// Revision: 1.0
// =====================================================================
interface spi_slave_port_if;
  logic [15:0] data_from_cpu;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic        spi_select;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;
  logic        endofpacket;

  modport slave (
    input  data_from_cpu, mem_addr, read_n, write_n, spi_select,
    output data_to_cpu, irq, dataavailable, readyfordata, endofpacket
  );

  modport master (
    output data_from_cpu, mem_addr, read_n, write_n, spi_select,
    input  data_to_cpu, irq, dataavailable, readyfordata, endofpacket
  );
endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// =====================================================================
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses taken from
// the last two stages.  Revision: 1.0
// =====================================================================
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stage <= {STAGES{RESET_VAL}};
    else          stage <= {stage[STAGES-2:0], din};
  end

  assign sync = stage[STAGES-1];
  assign rise = stage[STAGES-2] & ~stage[STAGES-1];
  assign fall = ~stage[STAGES-2] & stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_port.sv
`default_nettype none
// =====================================================================
// spi_slave_port: mode-0 MSB-first SPI slave, oversampled in clk, with a
// 16-bit CPU register port.  Revision: 1.0
// =====================================================================
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic SCLK,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic MISO_oe,
  spi_slave_port_if.slave bus
);

  localparam int CNT_W = $clog2(DATABITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATABITS - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, sel_end, sel_start;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset_n(reset_n), .din(SCLK),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
    .clk(clk), .reset_n(reset_n), .din(SS_n),
    .sync(ss_sync), .rise(sel_end), .fall(sel_start));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .din(MOSI),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));

  logic [DATABITS-1:0] shift_tx, shift_rx, tx_holding, rx_holding;
  logic [CNT_W-1:0]    bitcnt;
  logic                primed, need_load;
  logic                roe, toe, rrdy, eop;
  logic [15:0]         ctrl, eop_val, data_to_cpu, status_word, read_mux;
  logic                irq, irq_next;
  logic                rd_req_d, wr_req_d;

  logic selected, rise_act, fall_act, word_done, do_load;
  logic rd_req, wr_req, rd_strobe, wr_strobe;
  logic rx_read, stat_wr, tx_wr, tx_accept, overrun, rx_eop_hit, tx_eop_hit;
  logic [DATABITS:0]   rx_shifted;
  logic [DATABITS-1:0] rx_word;
  logic unused_ok;

  assign unused_ok = ^{sclk_sync, mosi_rise, mosi_fall, rx_shifted[DATABITS]};

  // SCLK edges outside selection, or coinciding with deselect, are ignored.
  assign selected  = ~ss_sync;
  assign rise_act  = sclk_rise & selected & ~sel_end;
  assign fall_act  = sclk_fall & selected & ~sel_end;
  assign word_done = rise_act & (bitcnt == LAST_BIT);
  assign do_load   = sel_start | (fall_act & need_load);

  assign rx_shifted = {shift_rx, mosi_sync};
  assign rx_word    = rx_shifted[DATABITS-1:0];

  assign rd_req    = bus.spi_select & ~bus.read_n;
  assign wr_req    = bus.spi_select & ~bus.write_n;
  assign rd_strobe = rd_req & ~rd_req_d;
  assign wr_strobe = wr_req & ~wr_req_d;

  assign rx_read    = rd_strobe & (bus.mem_addr == ADDR_RXDATA);
  assign stat_wr    = wr_strobe & (bus.mem_addr == ADDR_STATUS);
  assign tx_wr      = wr_strobe & (bus.mem_addr == ADDR_TXDATA);
  assign tx_accept  = tx_wr & ~primed;
  assign overrun    = word_done & rrdy & ~rx_read;
  assign rx_eop_hit = (16'(rx_word) == eop_val);
  assign tx_eop_hit = (16'(bus.data_from_cpu[DATABITS-1:0]) == eop_val);

  always_comb begin
    status_word          = '0;
    status_word[ST_ROE]  = roe;
    status_word[ST_TOE]  = toe;
    status_word[ST_TMT]  = ~selected & ~primed;
    status_word[ST_TRDY] = ~primed;
    status_word[ST_RRDY] = rrdy;
    status_word[ST_E]    = roe | toe;
    status_word[ST_EOP]  = eop;
  end

  always_comb begin
    read_mux = '0;
    case (bus.mem_addr)
      ADDR_RXDATA:  read_mux = 16'(rx_holding);
      ADDR_STATUS:  read_mux = status_word;
      ADDR_CONTROL: read_mux = ctrl;
      ADDR_EOP:     read_mux = eop_val;
      default:      read_mux = '0;
    endcase
  end

  assign irq_next = (eop & ctrl[CTL_IEOP]) | ((roe | toe) & ctrl[CTL_IE]) |
                    (rrdy & ctrl[CTL_IRRDY]) | (~primed & ctrl[CTL_ITRDY]) |
                    (toe & ctrl[CTL_ITOE]) | (roe & ctrl[CTL_IROE]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_d    <= 1'b0;
      wr_req_d    <= 1'b0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
      ctrl        <= '0;
      eop_val     <= '0;
    end else begin
      rd_req_d <= rd_req;
      wr_req_d <= wr_req;
      irq      <= irq_next;
      if (rd_strobe) data_to_cpu <= read_mux;
      if (wr_strobe && bus.mem_addr == ADDR_CONTROL) ctrl <= bus.data_from_cpu & CTL_MASK;
      if (wr_strobe && bus.mem_addr == ADDR_EOP)     eop_val <= bus.data_from_cpu;
    end
  end

  // A write landing with a load keeps the new data primed for the next word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_holding <= '0;
      primed     <= 1'b0;
      shift_tx   <= '0;
      toe        <= 1'b0;
    end else begin
      if (tx_accept) tx_holding <= bus.data_from_cpu[DATABITS-1:0];
      if (tx_accept)    primed <= 1'b1;
      else if (do_load) primed <= 1'b0;
      if (do_load)                      shift_tx <= primed ? tx_holding : '0;
      else if (fall_act && bitcnt != '0) shift_tx <= shift_tx << 1;
      if ((tx_wr & primed) | (do_load & ~primed)) toe <= 1'b1;
      else if (stat_wr)                           toe <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_rx   <= '0;
      rx_holding <= '0;
      bitcnt     <= '0;
      need_load  <= 1'b0;
      rrdy       <= 1'b0;
      roe        <= 1'b0;
      eop        <= 1'b0;
    end else begin
      if (rise_act)  shift_rx   <= rx_word;
      if (word_done) rx_holding <= rx_word;
      if (sel_start || sel_end || word_done) bitcnt <= '0;
      else if (rise_act)                     bitcnt <= bitcnt + CNT_W'(1);
      if (sel_end || do_load) need_load <= 1'b0;
      else if (word_done)     need_load <= 1'b1;
      if (word_done)                rrdy <= 1'b1;
      else if (rx_read || stat_wr)  rrdy <= 1'b0;
      if (overrun)      roe <= 1'b1;
      else if (stat_wr) roe <= 1'b0;
      if ((word_done & rx_eop_hit) | (tx_wr & tx_eop_hit)) eop <= 1'b1;
      else if (stat_wr)                                   eop <= 1'b0;
    end
  end

  assign MISO    = selected & shift_tx[DATABITS-1];
  assign MISO_oe = selected;

  assign bus.data_to_cpu   = data_to_cpu;
  assign bus.irq           = irq;
  assign bus.dataavailable = rrdy;
  assign bus.readyfordata  = ~primed;
  assign bus.endofpacket   = eop;

endmodule
`default_nettype wire

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave, mode 0 (CPOL=0, CPHA=0), MSB-first, with a 16-bit CPU register port.
- Other end of the link driven by our SPI master peripheral; lets an FPGA-hosted CPU act as a target on an external or looped-back SPI bus.
- SPI inputs are oversampled and edge-detected in the clk domain; no logic runs on SCLK.

Parameters:
- DATABITS, 8, word length in bits (1..16); unused upper bits of data_from_cpu ignored; unused upper bits of rxdata read as 0.
- SYNC_STAGES, 2, synchronizer depth for SCLK, SS_n and MOSI (>=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- SCLK  in  1  SPI clock from master.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_oe  out  1  MISO output enable (1 while selected).
- data_from_cpu  in  16  CPU write data.
- mem_addr  in  3  register address.
- read_n  in  1  CPU read, active-low.
- write_n  in  1  CPU write, active-low.
- spi_select  in  1  chip select for the register port.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
- dataavailable  out  1  = RRDY.
- readyfordata  out  1  = TRDY.
- endofpacket  out  1  = EOP.

Behaviour:
- Reset: reset reset_n, asynchronous, active-low; clock clk. All registers clear; MISO=0, MISO_oe=0, data_to_cpu=0, irq=0. TRDY=1 and TMT=1 out of reset.
- Register map:
  - 0: rxdata (r).
  - 1: txdata (w).
  - 2: status (r; any write clears EOP, ROE, TOE, RRDY).
  - 3: control (r/w).
  - 6: eop value (r/w, 16b).
  - 4, 5, 7: read 0, writes ignored.
- Status bits: ROE[3], TOE[4], TMT[5], TRDY[6], RRDY[7], E[8]=ROE|TOE, EOP[9]. Other bits 0.
- Control bits: iROE[3], iTOE[4], iTRDY[6], iRRDY[7], iE[8], iEOP[9]. Other bits read 0.
- Bus access: reads and writes are two-cycle events.
  - Strobe asserts for one cycle on the first cycle of spi_select & ~read_n (or ~write_n).
  - data_to_cpu is registered and valid on cycle 2.
  - Register side effects occur on the strobe cycle.
- Synchronization: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected from the last two stages: rise_evt, fall_evt, sel_start (SS falling), sel_end (SS rising).
  - Requirement on the master: SCLK period >= 8 clk.
- Transmit path:
  - txdata write with TRDY=1: tx_holding <= data, primed <= 1.
  - txdata write with TRDY=0: data dropped, TOE <= 1.
  - TRDY = ~primed.
- Word load:
  - Occurs on sel_start, and on the first fall_evt after a word completes while still selected.
  - If primed: shift_tx <= tx_holding, primed <= 0.
  - If not primed (underrun): shift_tx <= 0, TOE <= 1.
  - If a CPU write and a load hit the same cycle, the holding register takes the new data and primed stays 1.
- MISO: = shift_tx[DATABITS-1] whenever synced SS is low. MISO_oe = ~SS_sync.
- Shifting:
  - fall_evt, mid-word: shift_tx shifts left.
  - rise_evt: shift_rx <= {shift_rx, MOSI_sync}; bitcnt += 1.
- Word complete (bitcnt reaches DATABITS on a rise_evt):
  - rx_holding <= received word; RRDY <= 1; bitcnt <= 0.
  - ROE <= 1 if RRDY was already 1; the old word is overwritten.
  - EOP <= 1 if the received word equals eop value.
- EOP is also set by a txdata write whose data equals eop value.
- rxdata read clears RRDY. If word completion and the rxdata read strobe fall in the same cycle, RRDY ends at 1 and ROE is not set.
- Status write in the same cycle as word completion: completion wins for RRDY/EOP/ROE.
- sel_end mid-word: bitcnt <= 0, partial word discarded, no flags changed, MISO_oe drops. The next sel_start reloads.
- TMT = ~selected & ~primed.
- irq (registered, 1-cycle latency) = (EOP&iEOP) | (E&iE) | (RRDY&iRRDY) | (TRDY&iTRDY) | (TOE&iTOE) | (ROE&iROE).

Decomposition:
- Shared package spi_pkg holds:
  - Register address constants (ADDR_RXDATA=0, ADDR_TXDATA=1, ADDR_STATUS=2, ADDR_CONTROL=3, ADDR_EOP=6).
  - Status and control bit-index constants, shared with the master.
- One sub-module: spi_sync_edge (SYNC_STAGES synchronizer plus rise/fall pulse outputs), instantiated three times.

Test Plan:
- Reset, then read status -> data_to_cpu=0x0060 (TMT|TRDY); MISO_oe=0.
- Write txdata=0xA5; master sends 0x3C at SCLK=clk/10 -> MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; status RRDY=1; with iRRDY=1, irq rises one cycle after completion.
- Two words under one SS with only the first preloaded -> second word on MISO is 0x00; TOE=1; E=1.
- Two words received without an rxdata read -> ROE=1; rxdata holds the second word.
- SS_n deasserted after 5 SCLK rising edges, then a full word 0x81 is sent -> rxdata=0x81; no ROE; RRDY set only once.
- Set eop value=0x0D and receive 0x0D -> EOP=1 (status bit 9); a status write clears EOP, RRDY, ROE and TOE.
